// File: rtl/fetch_ifid_stage.sv
// LEGv8 instruction fetch unit with IF/ID pipeline register.
// Keeps at most one memory request outstanding and handles decode stalls and branch redirects.
module fetch_ifid_stage #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_valid,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [N-1:0]  redirect_pc,
    output logic [31:0]   ifid_instr,
    output logic [N-1:0]  ifid_pc,
    output logic          ifid_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t        state, state_n;
    logic [N-1:0]  pc, pc_n, addr, addr_n, hold_pc, hold_pc_n, ifid_pc_n;
    logic [31:0]   hold_instr, hold_instr_n, ifid_instr_n;
    logic          ifid_valid_n;
    logic [N-1:0]  target, addr_inc;
    logic          unused_pc_bits;

    assign target         = {redirect_pc[N-1:2], 2'b00};
    assign addr_inc       = addr + {{(N-3){1'b0}}, 3'd4};
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign imem_req       = (state == FETCH) || (state == DROP);
    assign imem_addr      = addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            addr       <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            addr       <= addr_n;
            hold_pc    <= hold_pc_n;
            hold_instr <= hold_instr_n;
            ifid_pc    <= ifid_pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        addr_n       = addr;
        hold_pc_n    = hold_pc;
        hold_instr_n = hold_instr;
        ifid_pc_n    = ifid_pc;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;

        if (redirect_i) begin
            // A request still in flight must be drained before the new target is issued.
            ifid_valid_n = 1'b0;
            pc_n         = target;
            if ((state == FETCH || state == DROP) && !imem_valid) begin
                state_n = DROP;
            end else begin
                state_n = FETCH;
                addr_n  = target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                    addr_n  = pc;
                end
                FETCH: begin
                    if (imem_valid) begin
                        if (!stall_i) begin
                            ifid_instr_n = imem_rdata;
                            ifid_pc_n    = addr;
                            ifid_valid_n = 1'b1;
                            pc_n         = addr_inc;
                            addr_n       = addr_inc;
                        end else begin
                            hold_instr_n = imem_rdata;
                            hold_pc_n    = addr;
                            pc_n         = addr_inc;
                            state_n      = HOLD;
                        end
                    end else if (!stall_i) begin
                        ifid_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_instr_n = hold_instr;
                        ifid_pc_n    = hold_pc;
                        ifid_valid_n = 1'b1;
                        addr_n       = pc;
                        state_n      = FETCH;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        addr_n  = pc;
                        state_n = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: a variable-latency memory model feeds the main DUT,
// a scoreboard tracks which PCs must reach IF/ID, and a second zero-wait DUT covers PC wrap.
module tb_fetch_ifid_stage;

    localparam int N = 64;
    localparam logic [N-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [N-1:0]  redirect_pc = '0;

    logic          imem_req, imem_valid, ifid_valid;
    logic [N-1:0]  imem_addr, ifid_pc;
    logic [31:0]   imem_rdata, ifid_instr;

    logic          imem_req2, imem_valid2, ifid_valid2;
    logic [N-1:0]  imem_addr2, ifid_pc2;
    logic [31:0]   imem_rdata2, ifid_instr2;

    int            checks = 0;
    int            errors = 0;
    int            mem_lat = 0;
    int            cnt;
    logic          deliver_ok;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  exp_pc;

    fetch_ifid_stage #(.N(N), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
    );

    fetch_ifid_stage #(.N(N), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_valid(imem_valid2),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2), .ifid_valid(ifid_valid2)
    );

    always #5 clk = ~clk;

    // Memory model: the response arrives once the request has waited mem_lat cycles.
    assign imem_valid  = imem_req && (cnt >= mem_lat);
    assign imem_rdata  = 32'hF840_0000 ^ imem_addr[31:0];
    assign imem_valid2 = imem_req2;
    assign imem_rdata2 = 32'hF840_0000;

    always @(posedge clk or negedge reset) begin
        if (!reset)                      cnt <= 0;
        else if (!imem_req || imem_valid) cnt <= 0;
        else                             cnt <= cnt + 1;
    end

    // A new instruction enters IF/ID only on an edge where decode was not stalled.
    always @(posedge clk) deliver_ok <= reset && !stall_i;

    always @(negedge clk) begin
        if (deliver_ok && ifid_valid && exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            checks++;
            if (ifid_pc !== exp_pc || ifid_instr !== (32'hF840_0000 ^ exp_pc[31:0])) begin
                errors++;
                $display("[TB] FAIL scoreboard got pc=%h instr=%h expected pc=%h instr=%h",
                         ifid_pc, ifid_instr, exp_pc, 32'hF840_0000 ^ exp_pc[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        reset       = 1'b0;
        stall_i     = 1'b0;
        redirect_i  = 1'b0;
        redirect_pc = '0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_lat = 0;
        do_reset();
        repeat (3) @(negedge clk);
        stall_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got req=%b valid=%b expected 0 0", imem_req, ifid_valid);
        end
        checks++;
        if (ifid_pc !== '0 || ifid_instr !== '0 || imem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got pc=%h instr=%h addr=%h expected zeros", ifid_pc, ifid_instr, imem_addr);
        end
        checks++;
        if (imem_addr2 !== WRAP_PC) begin
            errors++;
            $display("[TB] FAIL reset_pc_param got=%h expected=%h", imem_addr2, WRAP_PC);
        end
        stall_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release got req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] want;
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(N'(i * 4));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            want = N'(i * 4);
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== want || ifid_instr !== (32'hF840_0000 ^ want[31:0])) begin
                errors++;
                $display("[TB] FAIL back_to_back got valid=%b pc=%h instr=%h expected 1 %h %h",
                         ifid_valid, ifid_pc, ifid_instr, want, 32'hF840_0000 ^ want[31:0]);
            end
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drained got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        mem_lat = 0;
        do_reset();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'hC);
        repeat (3) @(negedge clk);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || ifid_pc !== 64'h4 || ifid_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold got req=%b pc=%h valid=%b expected 0 4 1", imem_req, ifid_pc, ifid_valid);
            end
        end
        stall_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ifid_pc !== 64'h8 || ifid_valid !== 1'b1 || imem_addr !== 64'hC) begin
            errors++;
            $display("[TB] FAIL stall_release got pc=%h valid=%b addr=%h expected 8 1 c", ifid_pc, ifid_valid, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (ifid_pc !== 64'hC) begin
            errors++;
            $display("[TB] FAIL stall_next got pc=%h expected c", ifid_pc);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_drained got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found;
        mem_lat = 3;
        do_reset();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = imem_req && (imem_addr == 64'h8);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL wait_addr8 got addr=%h expected 8 within 40 cycles", imem_addr);
        end
        redirect_i  = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        redirect_i = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8) begin
            errors++;
            $display("[TB] FAIL drop_enter got valid=%b req=%b addr=%h expected 0 1 8", ifid_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_addr !== 64'h8 || imem_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_hold got addr=%h mem_valid=%b expected 8 1", imem_addr, imem_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 64'h100 || ifid_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_exit got addr=%h valid=%b expected 100 0", imem_addr, ifid_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = ifid_valid;
        end
        checks++;
        if (!found || ifid_pc !== 64'h100) begin
            errors++;
            $display("[TB] FAIL redirect_target got valid=%b pc=%h expected 1 100", ifid_valid, ifid_pc);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL redirect_drained got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_stall();
        mem_lat = 0;
        do_reset();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h100);
        repeat (3) @(negedge clk);
        stall_i     = 1'b1;
        redirect_i  = 1'b1;
        redirect_pc = 64'h103;
        @(negedge clk);
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 64'h100) begin
            errors++;
            $display("[TB] FAIL redir_stall got valid=%b addr=%h expected 0 100", ifid_valid, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 64'h100) begin
            errors++;
            $display("[TB] FAIL redir_stall_fetch got valid=%b pc=%h expected 1 100", ifid_valid, ifid_pc);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL redir_stall_drained got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        mem_lat = 0;
        do_reset();
        @(negedge clk);
        checks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== WRAP_PC) begin
            errors++;
            $display("[TB] FAIL wrap_first_req got req=%b addr=%h expected 1 %h", imem_req2, imem_addr2, WRAP_PC);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid2 !== 1'b1 || ifid_pc2 !== WRAP_PC || ifid_instr2 !== 32'hF840_0000) begin
            errors++;
            $display("[TB] FAIL wrap_top got valid=%b pc=%h instr=%h expected 1 %h f8400000",
                     ifid_valid2, ifid_pc2, ifid_instr2, WRAP_PC);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid2 !== 1'b1 || ifid_pc2 !== 64'h0 || imem_addr2 !== 64'h4) begin
            errors++;
            $display("[TB] FAIL wrap_zero got valid=%b pc=%h addr=%h expected 1 0 4", ifid_valid2, ifid_pc2, imem_addr2);
        end
    endtask

    initial begin
        $display("[TB] starting fetch_ifid_stage bench");
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_outstanding();
        test_redirect_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
